// File: rtl/io_hub_pkg.sv
// Constants shared by io_rx_ctrl and io_hub: FSM encoding, config map, status layout.
package io_hub_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
    S_DONE = 2'd2
  } rx_state_t;

  localparam logic [1:0] CFG_CTRL  = 2'd0;
  localparam logic [1:0] CFG_FIRST = 2'd1;
  localparam logic [1:0] CFG_END   = 2'd2;
  localparam logic [1:0] CFG_RSVD  = 2'd3;

  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;

  localparam int ST_BUSY    = 0;
  localparam int ST_FINISH  = 1;
  localparam int ST_WR      = 2;
  localparam int ST_ABORT   = 3;
  localparam int ST_LEN_ERR = 4;
  localparam int ST_CNT_LSB = 16;
  localparam int ST_CNT_W   = 16;

  // io_hub register map for the status and window registers
  localparam logic [1:0] HUB_STATUS_ADDR = 2'd1;
  localparam logic [1:0] HUB_FIRST_ADDR  = 2'd2;
  localparam logic [1:0] HUB_END_ADDR    = 2'd3;

endpackage

// File: rtl/io_word_pack.sv
// Little-endian byte-to-word packer: lanes 0..2 are stored, lane 3 completes the word
// combinationally so the parent can register the full word on the accepting edge.
module io_word_pack (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_done_o
);

  logic [23:0] lanes_q, lanes_d;
  logic [1:0]  byte_idx_q, byte_idx_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lanes_q    <= '0;
      byte_idx_q <= '0;
    end else begin
      lanes_q    <= lanes_d;
      byte_idx_q <= byte_idx_d;
    end
  end

  always_comb begin
    lanes_d    = lanes_q;
    byte_idx_d = byte_idx_q;
    if (clear) begin
      lanes_d    = '0;
      byte_idx_d = '0;
    end else if (byte_en) begin
      case (byte_idx_q)
        2'd0:    lanes_d[7:0]   = byte_i;
        2'd1:    lanes_d[15:8]  = byte_i;
        2'd2:    lanes_d[23:16] = byte_i;
        default: lanes_d        = lanes_q;
      endcase
      byte_idx_d = byte_idx_q + 2'd1;
    end
  end

  assign word_o      = {byte_i, lanes_q};
  assign word_done_o = byte_en && !clear && (byte_idx_q == 2'd3);

endmodule

// File: rtl/io_rx_ctrl.sv
// Receive control: config window registers, transfer FSM, word counter and status word.
//   state  | meaning
//   S_IDLE | waiting for an accepted start; address registers writable
//   S_RECV | accepting bytes until len words delivered or abort
//   S_DONE | one cycle after the last word; finish set on exit
module io_rx_ctrl
  import io_hub_pkg::*;
#(
  parameter int MAX_WORDS = 8,
  parameter int CNT_W     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_we_i,
  input  logic [1:0]  cfg_addr_i,
  input  logic [31:0] cfg_data_i,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_byte_i,
  output logic        rx_ready_o,
  output logic [31:0] data,
  output logic [31:0] status_reg,
  output logic [31:0] addr_first_reg,
  output logic [31:0] addr_end_reg
);

  localparam logic [CNT_W:0] MAX_LEN = (CNT_W+1)'(MAX_WORDS);
  localparam logic [CNT_W:0] ONE     = (CNT_W+1)'(1);

  rx_state_t        state_q, state_d;
  logic [31:0]      first_q, first_d, end_q, end_d, data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             finish_q, finish_d, abort_q, abort_d;
  logic             len_err_q, len_err_d, wr_q, wr_d;
  logic             busy;

  logic             ctrl_wr, start_req, abort_req, len_ok;
  logic             start_ok, start_rej, abort_now, byte_en, word_done, last_word;
  logic [CNT_W:0]   len_w, cnt_inc;
  logic [31:0]      word;

  assign ctrl_wr   = cfg_we_i && (cfg_addr_i == CFG_CTRL);
  assign abort_req = ctrl_wr && cfg_data_i[CTRL_ABORT];
  assign start_req = ctrl_wr && cfg_data_i[CTRL_START] && !cfg_data_i[CTRL_ABORT];

  assign len_w     = {1'b0, end_q[CNT_W-1:0]} - {1'b0, first_q[CNT_W-1:0]} + ONE;
  assign len_ok    = (end_q[CNT_W-1:0] >= first_q[CNT_W-1:0]) && (len_w <= MAX_LEN);
  assign start_ok  = start_req && (state_q == S_IDLE) && len_ok;
  assign start_rej = start_req && (state_q == S_IDLE) && !len_ok;
  assign abort_now = abort_req && (state_q == S_RECV);

  // an abort on the same edge as a byte discards that byte
  assign byte_en   = rx_valid_i && rx_ready_o && !abort_now;
  assign cnt_inc   = {1'b0, cnt_q} + ONE;
  assign last_word = word_done && (cnt_inc == len_w);

  io_word_pack u_pack (
    .clk         (clk),
    .rst         (rst),
    .clear       (start_ok || abort_now),
    .byte_en     (byte_en),
    .byte_i      (rx_byte_i),
    .word_o      (word),
    .word_done_o (word_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_ok) state_d = S_RECV;
      S_RECV: begin
        if (abort_now)      state_d = S_IDLE;
        else if (last_word) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rx_ready_o = (state_q == S_RECV);
    busy       = (state_q == S_RECV);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_q   <= '0;
      end_q     <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      finish_q  <= 1'b0;
      abort_q   <= 1'b0;
      len_err_q <= 1'b0;
      wr_q      <= 1'b0;
    end else begin
      first_q   <= first_d;
      end_q     <= end_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      finish_q  <= finish_d;
      abort_q   <= abort_d;
      len_err_q <= len_err_d;
      wr_q      <= wr_d;
    end
  end

  always_comb begin
    first_d   = first_q;
    end_d     = end_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    finish_d  = finish_q;
    abort_d   = abort_q;
    len_err_d = len_err_q;
    wr_d      = 1'b0;
    if (cfg_we_i && (state_q == S_IDLE)) begin
      if (cfg_addr_i == CFG_FIRST) first_d = cfg_data_i;
      if (cfg_addr_i == CFG_END)   end_d   = cfg_data_i;
    end
    if (start_rej) len_err_d = 1'b1;
    if (start_ok) begin
      finish_d  = 1'b0;
      abort_d   = 1'b0;
      len_err_d = 1'b0;
      cnt_d     = '0;
    end
    if (abort_now) abort_d = 1'b1;
    if (word_done) begin
      data_d = word;
      wr_d   = 1'b1;
      cnt_d  = cnt_inc[CNT_W-1:0];
    end
    if (state_q == S_DONE) finish_d = 1'b1;
  end

  always_comb begin
    status_reg                                = '0;
    status_reg[ST_BUSY]                       = busy;
    status_reg[ST_FINISH]                     = finish_q;
    status_reg[ST_WR]                         = wr_q;
    status_reg[ST_ABORT]                      = abort_q;
    status_reg[ST_LEN_ERR]                    = len_err_q;
    status_reg[ST_CNT_LSB +: ST_CNT_W]        = ST_CNT_W'(cnt_q);
  end

  assign data           = data_q;
  assign addr_first_reg = first_q;
  assign addr_end_reg   = end_q;

endmodule

// File: tb/tb_io_rx_ctrl.sv
// Directed bench for io_rx_ctrl: expected words queued when bytes are driven,
// popped and compared whenever the write strobe is seen.
module tb_io_rx_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we_i = 1'b0;
  logic [1:0]  cfg_addr_i = '0;
  logic [31:0] cfg_data_i = '0;
  logic        rx_valid_i = 1'b0;
  logic [7:0]  rx_byte_i = '0;
  logic        rx_ready_o;
  logic [31:0] data, status_reg, addr_first_reg, addr_end_reg;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int strobes = 0;
  int strobe_cyc[$];
  logic [31:0] exp_q[$];
  logic prev_wr = 1'b0;

  io_rx_ctrl #(.MAX_WORDS(8), .CNT_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_we_i       (cfg_we_i),
    .cfg_addr_i     (cfg_addr_i),
    .cfg_data_i     (cfg_data_i),
    .rx_valid_i     (rx_valid_i),
    .rx_byte_i      (rx_byte_i),
    .rx_ready_o     (rx_ready_o),
    .data           (data),
    .status_reg     (status_reg),
    .addr_first_reg (addr_first_reg),
    .addr_end_reg   (addr_end_reg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // scoreboard side: every strobe must match the oldest queued word and last one cycle
  always @(negedge clk) begin
    if (!rst && status_reg[2]) begin
      strobes++;
      strobe_cyc.push_back(cyc);
      check("strobe_single_cycle", {31'b0, prev_wr}, 32'h0);
      if (exp_q.size() == 0) check("unexpected_strobe", data, 32'hxxxx_xxxx);
      else check("word_data", data, exp_q.pop_front());
    end
    prev_wr = !rst && status_reg[2];
  end

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    cfg_we_i = 1'b1; cfg_addr_i = a; cfg_data_i = d;
    @(negedge clk);
    cfg_we_i = 1'b0; cfg_addr_i = '0; cfg_data_i = '0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    rx_byte_i = b; rx_valid_i = 1'b1;
    while (!rx_ready_o && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) check("send_byte_timeout", 32'(t), 32'd0);
    @(negedge clk);
    rx_valid_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    exp_q.push_back(w);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[i*8 +: 8]);
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic wait_finish(input string tag);
    int t = 0;
    while (!status_reg[1] && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) check(tag, 32'(t), 32'd0);
  endtask

  initial begin
    int s0;
    logic [31:0] w;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_data", data, 32'h0);
    check("rst_status", status_reg, 32'h0);
    check("rst_first", addr_first_reg, 32'h0);
    check("rst_end", addr_end_reg, 32'h0);
    check("rst_ready", {31'b0, rx_ready_o}, 32'h0);

    // basic two-word transfer, back-to-back bytes
    cfg_write(2'd1, 32'h10);
    cfg_write(2'd2, 32'h11);
    check("basic_first", addr_first_reg, 32'h10);
    check("basic_end", addr_end_reg, 32'h11);
    cfg_write(2'd0, 32'h1);
    check("basic_ready", {31'b0, rx_ready_o}, 32'h1);
    check("basic_busy", status_reg, 32'h0000_0001);
    send_word(32'h0403_0201, 1'b0);
    send_word(32'h0807_0605, 1'b0);
    check("basic_done_cycle", status_reg, 32'h0002_0004);
    @(negedge clk);
    check("basic_finish", status_reg, 32'h0002_0002);
    check("basic_strobe_gap", 32'(strobe_cyc[1] - strobe_cyc[0]), 32'd4);

    // length errors and the MAX_WORDS boundary
    cfg_write(2'd1, 32'h5);
    cfg_write(2'd2, 32'h4);
    cfg_write(2'd0, 32'h1);
    check("lenerr_rev_status", status_reg, 32'h0002_0012);
    check("lenerr_rev_ready", {31'b0, rx_ready_o}, 32'h0);
    cfg_write(2'd1, 32'h0);
    cfg_write(2'd2, 32'h7);
    cfg_write(2'd0, 32'h1);
    check("len8_accepted", status_reg, 32'h0000_0001);
    cfg_write(2'd0, 32'h2);
    check("len8_abort", status_reg, 32'h0000_0008);
    cfg_write(2'd2, 32'h8);
    cfg_write(2'd0, 32'h1);
    check("len9_status", status_reg, 32'h0000_0018);
    check("len9_ready", {31'b0, rx_ready_o}, 32'h0);

    // abort mid-word, then a clean single-word transfer
    cfg_write(2'd1, 32'h20);
    cfg_write(2'd2, 32'h20);
    cfg_write(2'd0, 32'h1);
    s0 = strobes;
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    cfg_write(2'd0, 32'h2);
    check("abort_status", status_reg, 32'h0000_0008);
    check("abort_no_strobe", 32'(strobes - s0), 32'd0);
    cfg_write(2'd0, 32'h1);
    send_word(32'hDDCC_BBAA, 1'b0);
    check("restart_done_cycle", status_reg, 32'h0001_0004);
    @(negedge clk);
    check("restart_finish", status_reg, 32'h0001_0002);

    // abort on the same edge as the 4th byte
    cfg_write(2'd0, 32'h1);
    s0 = strobes;
    send_byte(8'h41); send_byte(8'h42); send_byte(8'h43);
    rx_valid_i = 1'b1; rx_byte_i = 8'h44;
    cfg_we_i = 1'b1; cfg_addr_i = 2'd0; cfg_data_i = 32'h2;
    @(negedge clk);
    rx_valid_i = 1'b0; cfg_we_i = 1'b0; cfg_data_i = '0;
    check("abort4_status", status_reg, 32'h0000_0008);
    check("abort4_data_held", data, 32'hDDCC_BBAA);
    check("abort4_no_strobe", 32'(strobes - s0), 32'd0);

    // start+abort together is an abort; bytes while not ready are ignored
    cfg_write(2'd0, 32'h3);
    check("start_abort_ready", {31'b0, rx_ready_o}, 32'h0);
    rx_valid_i = 1'b1; rx_byte_i = 8'h99;
    repeat (3) @(negedge clk);
    rx_valid_i = 1'b0;
    check("idle_bytes_status", status_reg, 32'h0000_0008);

    // flow control with random gaps and address writes while busy
    cfg_write(2'd1, 32'h100);
    cfg_write(2'd2, 32'h102);
    cfg_write(2'd0, 32'h1);
    s0 = strobes;
    for (int k = 0; k < 3; k++) begin
      w = $urandom;
      send_word(w, 1'b1);
      if (k == 0) begin
        cfg_write(2'd1, 32'hDEAD);
        cfg_write(2'd2, 32'hBEEF);
        check("busy_first_kept", addr_first_reg, 32'h100);
        check("busy_end_kept", addr_end_reg, 32'h102);
      end
    end
    wait_finish("flow_finish_timeout");
    check("flow_strobes", 32'(strobes - s0), 32'd3);
    check("flow_status", status_reg, 32'h0003_0002);

    // asynchronous reset mid-transfer
    cfg_write(2'd1, 32'h20);
    cfg_write(2'd2, 32'h20);
    cfg_write(2'd0, 32'h1);
    send_byte(8'h01); send_byte(8'h02);
    #2 rst = 1'b1;
    #1;
    check("arst_status", status_reg, 32'h0);
    check("arst_data", data, 32'h0);
    check("arst_first", addr_first_reg, 32'h0);
    check("arst_end", addr_end_reg, 32'h0);
    check("arst_ready", {31'b0, rx_ready_o}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    cfg_write(2'd0, 32'h1);
    send_word(32'hCAFE_F00D, 1'b0);
    wait_finish("post_rst_finish_timeout");
    check("post_rst_status", status_reg, 32'h0001_0002);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
